// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read path and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU with HI/LO: shift-add multiplier and restoring divider on one
// magnitude datapath, WIDTH iterations followed by a single sign-fix cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   raw_a;
    logic [2*WIDTH-1:0] acc;

    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   abs_a_c;
    logic [WIDTH-1:0]   abs_b_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     rem_shift_c;
    logic               rem_ge_c;
    logic [WIDTH-1:0]   rem_diff_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;

    // Operand magnitudes, one multiply/divide step, and final sign correction.
    always_comb begin
        a_neg_c     = ~bus.op[0] & bus.op_a[WIDTH-1];
        b_neg_c     = ~bus.op[0] & bus.op_b[WIDTH-1];
        abs_a_c     = a_neg_c ? -bus.op_a : bus.op_a;
        abs_b_c     = b_neg_c ? -bus.op_b : bus.op_b;
        sum_c       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        rem_shift_c = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
        rem_ge_c    = rem_shift_c >= {1'b0, mag_b};
        // Only used when rem_shift >= divisor, where the true difference fits in WIDTH bits.
        rem_diff_c  = rem_shift_c[WIDTH-1:0] - mag_b;
        prod_c      = neg_lo ? -acc : acc;
        quo_c       = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_c       = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            is_div       <= 1'b0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            dz           <= 1'b0;
            mag_a        <= '0;
            mag_b        <= '0;
            raw_a        <= '0;
            acc          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_hi) bus.hi <= bus.wr_data;
                    if (bus.wr_lo) bus.lo <= bus.wr_data;
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        mag_a    <= abs_a_c;
                        mag_b    <= abs_b_c;
                        raw_a    <= bus.op_a;
                        neg_lo   <= a_neg_c ^ b_neg_c;
                        neg_hi   <= a_neg_c;
                        dz       <= bus.op[1] & (bus.op_b == '0);
                        acc      <= '0;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        // Remainder in acc upper half, quotient bits shift into the lower half.
                        acc   <= {rem_ge_c ? rem_diff_c : rem_shift_c[WIDTH-1:0],
                                  acc[WIDTH-2:0], rem_ge_c};
                        mag_a <= {mag_a[WIDTH-2:0], 1'b0};
                    end else begin
                        acc   <= mag_b[0] ? {sum_c, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
                        mag_b <= mag_b >> 1;
                    end
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                    if (dz) begin
                        bus.hi       <= raw_a;
                        bus.lo       <= '1;
                        bus.div_zero <= 1'b1;
                    end else if (is_div) begin
                        bus.hi <= rem_c;
                        bus.lo <= quo_c;
                    end else begin
                        {bus.hi, bus.lo} <= prod_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO results are queued at issue time and
// checked by an independent monitor whenever done is seen.
module tb_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hi", 64'(bus.hi), 64'(e.hi));
                    chk("lo", 64'(bus.lo), 64'(e.lo));
                    chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
                if (prev_done) chk("done_width", 64'(1), 64'(0));
            end else if (bus.div_zero) begin
                chk("div_zero_without_done", 64'(1), 64'(0));
            end
        end
        prev_done <= bus.done;
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        if (push) sb.push_back('{hi: ehi, lo: elo, dz: edz, cyc: cyc + 1 + 33});
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
            if (!bus.busy) break;
            n++;
        end
        if (bus.busy) chk("busy_timeout", 64'(1), 64'(0));
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int n;
        issue(op, a, b, ehi, elo, edz, 1'b1);
        wait_idle(n);
        chk("busy_cycles", 64'(n), 64'(33));
    endtask

    initial begin
        int n;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_div_zero", 64'(bus.div_zero), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));
        reset = 1'b0;

        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run(OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0);
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1);

        // Start and MTLO while busy are both dropped.
        issue(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b1);
        repeat (9) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.start   = 1'b1;
        bus.op      = OP_DIVU;
        bus.op_a    = 32'd77;
        bus.op_b    = 32'd0;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        wait_idle(n);
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'hABCD_0000;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'(32'hABCD_0000));
        chk("mthi_lo", 64'(bus.lo), 64'(32'd30));
        chk("idle_busy", 64'(bus.busy), 64'(0));

        // Asynchronous reset mid-divide aborts it.
        issue(OP_DIV, 32'hFFFF_FF00, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (15) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_hi", 64'(bus.hi), 64'(0));
        chk("abort_lo", 64'(bus.lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        run(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
